// File: rtl/cpc_ram_bg_arbiter.sv
// Expansion SRAM arbiter: the Z80 bus always wins, one background requester
// uses idle bus windows. Optional macro BG_STARVE_WAIT_EN stalls the CPU once starved.
module cpc_ram_bg_arbiter #(
  parameter int IDLE_CLKS   = 2,
  parameter int BG_CYCLES   = 2,
  parameter int RETRY_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        mreq_b,
  input  logic        rfsh_b,
  input  logic        cpu_ramcs_b,
  input  logic [4:0]  cpu_ramadrhi,
  input  logic        bg_req,
  input  logic        bg_we,
  input  logic [18:0] bg_adr,
  input  logic [7:0]  bg_wdata,
  input  logic [7:0]  sram_rdata,
  output logic        bg_ack,
  output logic [7:0]  bg_rdata,
  output logic        ramcs_b,
  output logic        ramwe_b,
  output logic        ramoe_b,
  output logic [4:0]  ramadrhi,
  output logic        bg_sel,
  output logic        starve,
  output logic        wait_b
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  idle_cnt_reg, idle_cnt_next;
  logic [2:0]  cyc_cnt_reg, cyc_cnt_next;
  logic [3:0]  retry_cnt_reg, retry_cnt_next;
  logic        starve_reg, starve_next;
  logic [7:0]  rdata_reg, rdata_next;
  logic        wait_reg, wait_next;
  logic        forced;
  logic        abort;
  logic        in_access;

  // Low address bits and write data go to the external mux, not through here.
  logic unused;
  assign unused = ^{bg_adr[13:0], bg_wdata};

`ifdef BG_STARVE_WAIT_EN
  assign forced = ~wait_reg;
`else
  assign forced = 1'b0;
`endif

  assign abort     = ~mreq_b & ~forced;
  assign in_access = (state_reg == S_ACCESS);

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_reg     <= S_IDLE;
      idle_cnt_reg  <= '0;
      cyc_cnt_reg   <= '0;
      retry_cnt_reg <= '0;
      starve_reg    <= 1'b0;
      rdata_reg     <= '0;
      wait_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      idle_cnt_reg  <= idle_cnt_next;
      cyc_cnt_reg   <= cyc_cnt_next;
      retry_cnt_reg <= retry_cnt_next;
      starve_reg    <= starve_next;
      rdata_reg     <= rdata_next;
      wait_reg      <= wait_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idle_cnt_next  = idle_cnt_reg;
    cyc_cnt_next   = cyc_cnt_reg;
    retry_cnt_next = retry_cnt_reg;
    rdata_next     = rdata_reg;
    wait_next      = wait_reg;

    // The window restarts during an access so a new one is counted from DONE.
    if (in_access || !(mreq_b && rfsh_b))
      idle_cnt_next = '0;
    else if (idle_cnt_reg < 4'(IDLE_CLKS))
      idle_cnt_next = idle_cnt_reg + 4'd1;

    case (state_reg)
      S_IDLE: begin
`ifdef BG_STARVE_WAIT_EN
        if (bg_req && retry_cnt_reg == 4'(RETRY_LIMIT) && !mreq_b)
          wait_next = 1'b0;
`endif
        if (bg_req && (idle_cnt_reg == 4'(IDLE_CLKS) || forced)) begin
          state_next   = S_ACCESS;
          cyc_cnt_next = 3'(BG_CYCLES);
        end
      end
      S_ACCESS: begin
        if (abort) begin
          state_next = S_IDLE;
          if (retry_cnt_reg != 4'hF)
            retry_cnt_next = retry_cnt_reg + 4'd1;
        end else begin
          cyc_cnt_next = cyc_cnt_reg - 3'd1;
          if (cyc_cnt_reg == 3'd1) begin
            if (!bg_we)
              rdata_next = sram_rdata;
            state_next = S_DONE;
            wait_next  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_next     = S_IDLE;
        retry_cnt_next = '0;
      end
      default: state_next = S_IDLE;
    endcase

    starve_next = starve_reg | (retry_cnt_next == 4'(RETRY_LIMIT));
  end

  // Outputs sit at their reset values for as long as reset is held.
  always_comb begin
    bg_ack   = 1'b0;
    bg_rdata = '0;
    ramcs_b  = 1'b1;
    ramwe_b  = 1'b1;
    ramoe_b  = 1'b1;
    ramadrhi = '0;
    bg_sel   = 1'b0;
    starve   = 1'b0;
    wait_b   = 1'b1;
    if (reset_b) begin
      bg_ack   = (state_reg == S_DONE);
      bg_rdata = rdata_reg;
      starve   = starve_reg;
      wait_b   = wait_reg;
      bg_sel   = in_access;
      if (in_access) begin
        ramcs_b  = 1'b0;
        ramadrhi = bg_adr[18:14];
        // WE* rises one clock before CS* so write data is held past it.
        ramwe_b  = ~(bg_we && cyc_cnt_reg != 3'd1);
        ramoe_b  = bg_we;
      end else begin
        ramcs_b  = cpu_ramcs_b | mreq_b;
        ramadrhi = cpu_ramadrhi;
      end
    end
  end

endmodule

// File: tb/tb_cpc_ram_bg_arbiter.sv
// Directed bench for cpc_ram_bg_arbiter; acks are checked by a queue-based
// scoreboard monitor, strobe timing by inline checks.
module tb_cpc_ram_bg_arbiter;

  logic        clk;
  logic        reset_b;
  logic        mreq_b;
  logic        rfsh_b;
  logic        cpu_ramcs_b;
  logic [4:0]  cpu_ramadrhi;
  logic        bg_req;
  logic        bg_we;
  logic [18:0] bg_adr;
  logic [7:0]  bg_wdata;
  logic [7:0]  sram_rdata;
  logic        bg_ack;
  logic [7:0]  bg_rdata;
  logic        ramcs_b;
  logic        ramwe_b;
  logic        ramoe_b;
  logic [4:0]  ramadrhi;
  logic        bg_sel;
  logic        starve;
  logic        wait_b;

  int checks = 0;
  int failures = 0;
  int n_acks = 0;
  logic [7:0] exp_q[$];

  cpc_ram_bg_arbiter dut (
    .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .rfsh_b(rfsh_b),
    .cpu_ramcs_b(cpu_ramcs_b), .cpu_ramadrhi(cpu_ramadrhi),
    .bg_req(bg_req), .bg_we(bg_we), .bg_adr(bg_adr), .bg_wdata(bg_wdata),
    .sram_rdata(sram_rdata), .bg_ack(bg_ack), .bg_rdata(bg_rdata),
    .ramcs_b(ramcs_b), .ramwe_b(ramwe_b), .ramoe_b(ramoe_b),
    .ramadrhi(ramadrhi), .bg_sel(bg_sel), .starve(starve), .wait_b(wait_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bg_ack === 1'b1) begin
      n_acks++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("ack %0d bg_rdata=%02h expected=%02h", n_acks, bg_rdata, e);
        chk("ack_rdata", {24'd0, bg_rdata}, {24'd0, e});
      end
    end
  end

  task automatic issue(input logic we, input logic [18:0] adr, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input bit push);
    bg_req   = 1'b1;
    bg_we    = we;
    bg_adr   = adr;
    bg_wdata = wd;
    if (push) exp_q.push_back(exp_rd);
  endtask

  task automatic wait_sel(input string name, output int n);
    n = 0;
    while (bg_sel !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bg_sel !== 1'b1) chk({name, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    while (bg_ack !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bg_ack !== 1'b1) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
    bg_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bg_ack"},   {31'd0, bg_ack},   32'd0);
    chk({tag, "_bg_rdata"}, {24'd0, bg_rdata}, 32'd0);
    chk({tag, "_bg_sel"},   {31'd0, bg_sel},   32'd0);
    chk({tag, "_starve"},   {31'd0, starve},   32'd0);
    chk({tag, "_wait_b"},   {31'd0, wait_b},   32'd1);
    chk({tag, "_ramcs_b"},  {31'd0, ramcs_b},  32'd1);
    chk({tag, "_ramwe_b"},  {31'd0, ramwe_b},  32'd1);
    chk({tag, "_ramoe_b"},  {31'd0, ramoe_b},  32'd1);
    chk({tag, "_ramadrhi"}, {27'd0, ramadrhi}, 32'd0);
  endtask

  initial begin
    int n;
    reset_b = 1'b0; mreq_b = 1'b1; rfsh_b = 1'b1;
    cpu_ramcs_b = 1'b1; cpu_ramadrhi = 5'h15;
    bg_req = 1'b0; bg_we = 1'b0; bg_adr = '0; bg_wdata = '0; sram_rdata = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");

    // Write 0x7C123 <- 0xA5 after two idle clocks
    reset_b = 1'b1;
    issue(1'b1, 19'h7C123, 8'hA5, 8'h00, 1'b1);
    tick(); chk("wr_idle1_bg_sel", {31'd0, bg_sel}, 32'd0);
    tick(); chk("wr_idle2_bg_sel", {31'd0, bg_sel}, 32'd0);
    tick();
    chk("wr_a1_bg_sel",   {31'd0, bg_sel},   32'd1);
    chk("wr_a1_ramadrhi", {27'd0, ramadrhi}, 32'h1F);
    chk("wr_a1_ramcs_b",  {31'd0, ramcs_b},  32'd0);
    chk("wr_a1_ramwe_b",  {31'd0, ramwe_b},  32'd0);
    chk("wr_a1_ramoe_b",  {31'd0, ramoe_b},  32'd1);
    tick();
    chk("wr_a2_ramcs_b",  {31'd0, ramcs_b},  32'd0);
    chk("wr_a2_ramwe_b",  {31'd0, ramwe_b},  32'd1);
    tick();
    chk("wr_done_bg_ack", {31'd0, bg_ack},   32'd1);
    chk("wr_done_bg_sel", {31'd0, bg_sel},   32'd0);
    chk("wr_done_ramcs_b", {31'd0, ramcs_b}, 32'd1);
    bg_req = 1'b0;

    // Pass-through follows cpu_ramcs_b | mreq_b
    cpu_ramcs_b = 1'b0; cpu_ramadrhi = 5'h0A; mreq_b = 1'b0; #1;
    chk("pt_ramcs_b",  {31'd0, ramcs_b},  32'd0);
    chk("pt_ramadrhi", {27'd0, ramadrhi}, 32'h0A);
    mreq_b = 1'b1; #1;
    chk("pt_mreq_hi_ramcs_b", {31'd0, ramcs_b}, 32'd1);
    cpu_ramcs_b = 1'b1;

    // Read 0x04000 -> 0x3C
    sram_rdata = 8'h3C;
    issue(1'b0, 19'h04000, 8'h00, 8'h3C, 1'b1);
    wait_sel("rd", n);
    chk("rd_a1_ramoe_b",  {31'd0, ramoe_b},  32'd0);
    chk("rd_a1_ramwe_b",  {31'd0, ramwe_b},  32'd1);
    chk("rd_a1_ramadrhi", {27'd0, ramadrhi}, 32'h01);
    tick();
    chk("rd_a2_ramoe_b",  {31'd0, ramoe_b},  32'd0);
    chk("rd_a2_ramwe_b",  {31'd0, ramwe_b},  32'd1);
    tick();
    chk("rd_done_bg_ack", {31'd0, bg_ack},   32'd1);
    chk("rd_done_ramoe_b", {31'd0, ramoe_b}, 32'd1);
    bg_req = 1'b0;

    // Abort in the first access clock, then retry with a single ack
    issue(1'b1, 19'h12345, 8'h11, 8'h3C, 1'b1);
    wait_sel("ab", n);
    mreq_b = 1'b0;
    tick();
    chk("ab_bg_sel",  {31'd0, bg_sel},  32'd0);
    chk("ab_ramcs_b", {31'd0, ramcs_b}, 32'd1);
    chk("ab_ramwe_b", {31'd0, ramwe_b}, 32'd1);
    chk("ab_bg_ack",  {31'd0, bg_ack},  32'd0);
    mreq_b = 1'b1;
    wait_sel("ab_retry", n);
    wait_ack("ab_retry");

    // CPU access while the request is pending
    cpu_ramcs_b = 1'b0; cpu_ramadrhi = 5'h0D; mreq_b = 1'b0; sram_rdata = 8'h77;
    issue(1'b0, 19'h00000, 8'h00, 8'h77, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cpu_bg_sel",   {31'd0, bg_sel},   32'd0);
      chk("cpu_ramadrhi", {27'd0, ramadrhi}, 32'h0D);
    end
    mreq_b = 1'b1; cpu_ramcs_b = 1'b1;
    wait_sel("cpu", n);
    chk("cpu_start_delay", n, 32'd3);
    wait_ack("cpu");

    // Fifteen forced aborts set starve
    issue(1'b1, 19'h2AAAA, 8'h5A, 8'h77, 1'b1);
    for (int i = 0; i < 15; i++) begin
      wait_sel("stv", n);
      mreq_b = 1'b0;
      tick();
      mreq_b = 1'b1;
      if (i == 13) chk("stv_after14_starve", {31'd0, starve}, 32'd0);
    end
    chk("stv_after15_starve", {31'd0, starve}, 32'd1);
`ifdef BG_STARVE_WAIT_EN
    mreq_b = 1'b0;
    tick();
    chk("stv_wait_b_low", {31'd0, wait_b}, 32'd0);
    wait_ack("stv_forced");
    chk("stv_ack_wait_b", {31'd0, wait_b}, 32'd1);
    mreq_b = 1'b1;
`else
    chk("stv_wait_b_tied", {31'd0, wait_b}, 32'd1);
    wait_ack("stv");
`endif
    tick();
    chk("stv_sticky", {31'd0, starve}, 32'd1);

    // Reset in the middle of an access
    sram_rdata = 8'hEE;
    issue(1'b0, 19'h7FFFF, 8'h00, 8'h00, 1'b0);
    wait_sel("rst", n);
    reset_b = 1'b0; bg_req = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    repeat (2) tick();
    reset_b = 1'b1;
    repeat (5) tick();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
